// File: rtl/bfly12_stage.sv
// Stage-12 radix-2 FFT butterfly: distance-8 add/sub on sum and diff vectors,
// then W16^k twiddle on the difference half. Two-cycle pipeline, no stall.

module bfly12_twd #(
  parameter int W  = 16,
  parameter int WR = 256,
  parameter int WI = 0
) (
  input  logic signed [W-1:0] d_re,
  input  logic signed [W-1:0] d_im,
  output logic signed [W-1:0] y_re,
  output logic signed [W-1:0] y_im
);
  // Q2.8 products plus the rounding bias fit comfortably in W+12 bits
  localparam int PW = W + 12;
  localparam logic signed [PW-1:0] HI  = PW'((2 ** (W-1)) - 1);
  localparam logic signed [PW-1:0] LO  = -HI - PW'(1);
  localparam logic signed [PW-1:0] CR  = PW'(WR);
  localparam logic signed [PW-1:0] CI  = PW'(WI);
  localparam logic signed [PW-1:0] RND = PW'(128);

  logic signed [PW-1:0] xr, xi, pr, pi, rr, ri;

  always_comb begin
    xr = PW'(d_re);
    xi = PW'(d_im);
    pr = xr * CR - xi * CI + RND;
    pi = xr * CI + xi * CR + RND;
    rr = pr >>> 8;
    ri = pi >>> 8;
    y_re = (rr > HI) ? HI[W-1:0] : (rr < LO) ? LO[W-1:0] : rr[W-1:0];
    y_im = (ri > HI) ? HI[W-1:0] : (ri < LO) ? LO[W-1:0] : ri[W-1:0];
  end
endmodule

module bfly12_stage #(
  parameter int IN_W        = 15,
  parameter int OUT_W       = IN_W + 1,
  parameter int FRAME_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [15:0][IN_W-1:0]  twd_11_sum_re,
  input  logic [15:0][IN_W-1:0]  twd_11_sum_im,
  input  logic [15:0][IN_W-1:0]  twd_11_diff_re,
  input  logic [15:0][IN_W-1:0]  twd_11_diff_im,
  input  logic                   shift_12_valid,
  output logic [15:0][OUT_W-1:0] bfly12_sum_re,
  output logic [15:0][OUT_W-1:0] bfly12_sum_im,
  output logic [15:0][OUT_W-1:0] bfly12_diff_re,
  output logic [15:0][OUT_W-1:0] bfly12_diff_im,
  output logic                   shift_13_valid,
  output logic                   frame_last
);
  localparam int LANES  = 16;
  localparam int HALF   = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int W_RE [HALF] = '{256, 237, 181, 98, 0, -98, -181, -237};
  localparam int W_IM [HALF] = '{0, -98, -181, -237, -256, -237, -181, -98};

  // vector index 0 = sum path, 1 = diff path; both are processed identically
  logic [1:0][LANES-1:0][IN_W-1:0]  in_re, in_im;
  logic [1:0][HALF-1:0][OUT_W-1:0]  add_re, add_im, sub_re, sub_im;
  logic [1:0][HALF-1:0][OUT_W-1:0]  s1_a_re, s1_a_im, s1_d_re, s1_d_im;
  logic [1:0][HALF-1:0][OUT_W-1:0]  tw_re, tw_im;
  logic [1:0][LANES-1:0][OUT_W-1:0] out_re, out_im;
  logic [STAGES:1]                  vld_pipe, last_pipe;
  logic [CNT_W-1:0]                 beat_cnt;
  logic                             beat_last;

  assign in_re = {twd_11_diff_re, twd_11_sum_re};
  assign in_im = {twd_11_diff_im, twd_11_sum_im};

  always_comb begin
    add_re = '0;
    add_im = '0;
    sub_re = '0;
    sub_im = '0;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < HALF; k++) begin
        add_re[v][k] = OUT_W'($signed(in_re[v][k])) + OUT_W'($signed(in_re[v][k+HALF]));
        add_im[v][k] = OUT_W'($signed(in_im[v][k])) + OUT_W'($signed(in_im[v][k+HALF]));
        sub_re[v][k] = OUT_W'($signed(in_re[v][k])) - OUT_W'($signed(in_re[v][k+HALF]));
        sub_im[v][k] = OUT_W'($signed(in_im[v][k])) - OUT_W'($signed(in_im[v][k+HALF]));
      end
    end
  end

  for (genvar v = 0; v < 2; v++) begin : g_vec
    for (genvar k = 0; k < HALF; k++) begin : g_lane
      bfly12_twd #(.W(OUT_W), .WR(W_RE[k]), .WI(W_IM[k])) u_twd (
        .d_re (s1_d_re[v][k]),
        .d_im (s1_d_im[v][k]),
        .y_re (tw_re[v][k]),
        .y_im (tw_im[v][k])
      );
    end
  end

  assign beat_last = (beat_cnt == CNT_W'(FRAME_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rstn) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      beat_cnt  <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1], shift_12_valid};
      last_pipe <= {last_pipe[1], shift_12_valid & beat_last};
      if (shift_12_valid) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        s1_a_re  <= add_re;
        s1_a_im  <= add_im;
        s1_d_re  <= sub_re;
        s1_d_im  <= sub_im;
      end
      // outputs hold across gaps
      if (vld_pipe[1]) begin
        for (int v = 0; v < 2; v++) begin
          for (int k = 0; k < HALF; k++) begin
            out_re[v][k]      <= s1_a_re[v][k];
            out_im[v][k]      <= s1_a_im[v][k];
            out_re[v][k+HALF] <= tw_re[v][k];
            out_im[v][k+HALF] <= tw_im[v][k];
          end
        end
      end
    end
  end

  assign bfly12_sum_re  = out_re[0];
  assign bfly12_sum_im  = out_im[0];
  assign bfly12_diff_re = out_re[1];
  assign bfly12_diff_im = out_im[1];
  assign shift_13_valid = vld_pipe[STAGES];
  assign frame_last     = last_pipe[STAGES];
endmodule

// File: tb/tb_bfly12_stage.sv
// Scoreboard bench for bfly12_stage: directed identity/round/saturation,
// framing with gaps, mid-frame reset and a random run against a reference model.
module tb_bfly12_stage;
  localparam int IN_W = 15;
  localparam int OUT_W = 16;
  localparam int FB = 16;
  localparam int WR [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  localparam int WI [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  typedef logic [15:0][IN_W-1:0]  vec_i_t;
  typedef logic [15:0][OUT_W-1:0] vec_o_t;
  typedef struct {
    vec_o_t sre, sim, dre, dim;
    logic   last;
    int     cyc;
  } exp_t;

  logic   clk = 0;
  logic   rstn = 1;
  logic   valid = 0;
  vec_i_t sum_re = '0, sum_im = '0, diff_re = '0, diff_im = '0;
  vec_o_t bfly12_sum_re, bfly12_sum_im, bfly12_diff_re, bfly12_diff_im;
  logic   shift_13_valid, frame_last;

  int   checks = 0, errors = 0;
  int   cyc = 0, tb_cnt = 0, nout = 0;
  bit   started = 0;
  exp_t q[$];
  exp_t mon_e, hold_e;
  int   lastq[$];

  bfly12_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAME_BEATS(FB)) dut (
    .clk(clk), .rstn(rstn),
    .twd_11_sum_re(sum_re), .twd_11_sum_im(sum_im),
    .twd_11_diff_re(diff_re), .twd_11_diff_im(diff_im),
    .shift_12_valid(valid),
    .bfly12_sum_re(bfly12_sum_re), .bfly12_sum_im(bfly12_sum_im),
    .bfly12_diff_re(bfly12_diff_re), .bfly12_diff_im(bfly12_diff_im),
    .shift_13_valid(shift_13_valid), .frame_last(frame_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
  endfunction

  function automatic void model(input vec_i_t vr, input vec_i_t vi, output vec_o_t orr, output vec_o_t oi);
    int ar, ai, dr, di, pr, pi;
    orr = '0;
    oi  = '0;
    for (int k = 0; k < 8; k++) begin
      ar = int'($signed(vr[k])) + int'($signed(vr[k+8]));
      ai = int'($signed(vi[k])) + int'($signed(vi[k+8]));
      dr = int'($signed(vr[k])) - int'($signed(vr[k+8]));
      di = int'($signed(vi[k])) - int'($signed(vi[k+8]));
      pr = sat((dr * WR[k] - di * WI[k] + 128) >>> 8);
      pi = sat((dr * WI[k] + di * WR[k] + 128) >>> 8);
      orr[k]   = OUT_W'(ar);
      oi[k]    = OUT_W'(ai);
      orr[k+8] = OUT_W'(pr);
      oi[k+8]  = OUT_W'(pi);
    end
  endfunction

  function automatic vec_i_t rnd_vec();
    vec_i_t v;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 7))
        0:       v[i] = 15'h3FFF;
        1:       v[i] = 15'h4000;
        default: v[i] = IN_W'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drive_beat(input vec_i_t sr, input vec_i_t si, input vec_i_t dr, input vec_i_t di);
    exp_t e;
    sum_re = sr; sum_im = si; diff_re = dr; diff_im = di;
    valid = 1;
    model(sr, si, e.sre, e.sim);
    model(dr, di, e.dre, e.dim);
    e.last = (tb_cnt == FB - 1);
    tb_cnt = (tb_cnt == FB - 1) ? 0 : tb_cnt + 1;
    e.cyc = cyc + 2;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic gap();
    valid = 0;
    sum_re = rnd_vec(); diff_im = rnd_vec();
    @(posedge clk); #1;
  endtask

  // the beat presented alongside reset must be ignored
  task automatic do_reset(input int n);
    rstn = 1;
    valid = 1;
    sum_re = rnd_vec();
    @(posedge clk); #1;
    q.delete();
    hold_e = '{default: '0};
    tb_cnt = 0;
    repeat (n - 1) begin @(posedge clk); #1; end
    rstn = 0;
    valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) gap();
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (shift_13_valid) begin
        nout++;
        if (frame_last) lastq.push_back(nout);
        if (q.size() == 0) chk("spurious_valid", shift_13_valid, 0);
        else begin
          mon_e = q.pop_front();
          chk("latency", cyc, mon_e.cyc);
          chk("sum_re", bfly12_sum_re, mon_e.sre);
          chk("sum_im", bfly12_sum_im, mon_e.sim);
          chk("diff_re", bfly12_diff_re, mon_e.dre);
          chk("diff_im", bfly12_diff_im, mon_e.dim);
          chk("frame_last", frame_last, mon_e.last);
          hold_e = mon_e;
        end
      end else begin
        chk("hold_sum_re", bfly12_sum_re, hold_e.sre);
        chk("hold_sum_im", bfly12_sum_im, hold_e.sim);
        chk("hold_diff_re", bfly12_diff_re, hold_e.dre);
        chk("hold_diff_im", bfly12_diff_im, hold_e.dim);
        chk("last_gap", frame_last, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_i_t z, a, b;
    logic [OUT_W-1:0] e16;
    z = '0;
    hold_e = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);
    @(negedge clk);
    chk("rst_valid", shift_13_valid, 0);
    chk("rst_last", frame_last, 0);
    chk("rst_sum_re", bfly12_sum_re, 0);
    chk("rst_diff_im", bfly12_diff_im, 0);
    started = 1;
    @(posedge clk); #1;

    // identity: lane 0 = 100 produces 100 on both A[0] and D[0]
    a = z; a[0] = 15'd100;
    drive_beat(a, z, z, z);
    valid = 0;
    @(posedge clk); @(negedge clk);
    chk("id_lane0", bfly12_sum_re[0], 100);
    chk("id_lane8", bfly12_sum_re[8], 100);
    @(posedge clk); #1;
    gap(); gap();

    // round half up on W16^2
    a = z; a[2] = 15'd100;
    drive_beat(z, z, a, z);
    valid = 0;
    @(posedge clk); @(negedge clk);
    chk("rnd_re10", bfly12_diff_re[10], 71);
    e16 = -71;
    chk("rnd_im10", bfly12_diff_im[10], e16);
    @(posedge clk); #1;

    // saturation both directions, no wrap
    a = z; b = z;
    a[1] = 15'h3FFF; a[9] = 15'h4000; b[1] = 15'h4000; b[9] = 15'h3FFF;
    a[3] = 15'h3FFF; a[11] = 15'h4000; b[3] = 15'h3FFF; b[11] = 15'h4000;
    drive_beat(z, z, a, b);
    valid = 0;
    @(posedge clk); @(negedge clk);
    e16 = 16'h8000;
    chk("sat_im9", bfly12_diff_im[9], e16);
    chk("sat_re11", bfly12_diff_re[11], 32767);
    @(posedge clk); #1;
    drain();

    // framing: 40 beats, gap every third cycle
    do_reset(1);
    nout = 0; lastq.delete();
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 2) gap();
      else drive_beat(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    end
    drain();
    chk("frm_count", nout, 40);
    chk("frm_nlast", lastq.size(), 2);
    chk("frm_last0", (lastq.size() > 0) ? lastq[0] : 0, 16);
    chk("frm_last1", (lastq.size() > 1) ? lastq[1] : 0, 32);

    // reset mid-frame after beat 7
    for (int i = 0; i < 7; i++) drive_beat(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    do_reset(1);
    @(negedge clk);
    chk("mid_valid", shift_13_valid, 0);
    chk("mid_sum_re", bfly12_sum_re, 0);
    chk("mid_diff_re", bfly12_diff_re, 0);
    nout = 0; lastq.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) drive_beat(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    drain();
    chk("mid_count", nout, 16);
    chk("mid_nlast", lastq.size(), 1);
    chk("mid_last0", (lastq.size() > 0) ? lastq[0] : 0, 16);

    // random run with random gaps
    nout = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) gap();
      drive_beat(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    end
    drain();
    chk("rnd_count", nout, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
